// File: rtl/spectrum_pkg.sv
// Shared widths, types and FSM encoding for the spectrum peak tracker.
package spectrum_pkg;

  localparam int NBINS   = 8;
  localparam int MAG_W   = 13;
  localparam int LEVEL_W = 4;

  typedef logic [MAG_W-1:0]   mag_t;
  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } tracker_state_t;

endpackage

// File: rtl/spectrum_peak_tracker_msb_level.sv
// Leading-one encoder: 0 for a zero input, else floor(log2(value)) + 1.
module msb_level
  import spectrum_pkg::*;
(
  input  logic [MAG_W-1:0]   value,
  output logic [LEVEL_W-1:0] level
);

  // NOTE: assign a default before the loop so every path drives level and no latch is inferred.
  always_comb begin
    level = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (value[i]) level = LEVEL_W'(i + 1);
    end
  end

endmodule

// File: rtl/spectrum_peak_tracker.sv
// Per-frame smoothing, peak-hold with linear decay, bar levels and dominant-bin search
// over eight FFT magnitudes, processed one bin per clock after each update tick.
module spectrum_peak_tracker
  import spectrum_pkg::*;
#(
  parameter int FCLK        = 50_000_000,
  parameter int UPDATE_HZ   = 30,
  parameter int ALPHA_SHIFT = 2,
  parameter int DECAY_STEP  = 64,
  parameter int SEARCH_LO   = 1,
  parameter int SEARCH_HI   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MAG_W-1:0]   mag    [NBINS],
  output logic [MAG_W-1:0]   smooth [NBINS],
  output logic [MAG_W-1:0]   hold   [NBINS],
  output logic [LEVEL_W-1:0] level  [NBINS],
  output logic [2:0]         peak_bin,
  output logic [MAG_W-1:0]   peak_mag,
  output logic               frame_done
);

  localparam int               PERIOD   = FCLK / UPDATE_HZ;
  localparam int               CNT_W    = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [2:0]       LAST_BIN = 3'(NBINS - 1);
  localparam logic [2:0]       LO_BIN   = 3'(SEARCH_LO);
  localparam logic [2:0]       HI_BIN   = 3'(SEARCH_HI);
  localparam mag_t             DECAY    = MAG_W'(DECAY_STEP);

  if (PERIOD < 16) begin : g_period_check
    $error("spectrum_peak_tracker: FCLK/UPDATE_HZ must be at least 16");
  end
  if (ALPHA_SHIFT < 0 || ALPHA_SHIFT > 6) begin : g_alpha_check
    $error("spectrum_peak_tracker: ALPHA_SHIFT must lie in 0..6");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  tracker_state_t   state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  mag_t             snap_q   [NBINS];
  mag_t             snap_d   [NBINS];
  mag_t             smooth_q [NBINS];
  mag_t             smooth_d [NBINS];
  mag_t             hold_q   [NBINS];
  mag_t             hold_d   [NBINS];
  level_t           level_q  [NBINS];
  level_t           level_d  [NBINS];
  logic [2:0]       best_bin_q, best_bin_d;
  mag_t             best_mag_q, best_mag_d;
  logic [2:0]       peak_bin_q, peak_bin_d;
  mag_t             peak_mag_q, peak_mag_d;
  logic             frame_done_q, frame_done_d;

  logic tick;
  assign tick = (cnt_q == CNT_LAST);

  // Single-bin datapath for the bin selected by idx_q.
  mag_t                  cur_snap, cur_smooth, cur_hold;
  mag_t                  decayed, smooth_new, hold_new;
  level_t                level_new;
  logic signed [MAG_W:0] diff, step, sum;
  logic                  in_search;

  assign cur_snap   = snap_q[idx_q];
  assign cur_smooth = smooth_q[idx_q];
  assign cur_hold   = hold_q[idx_q];

  // New value lies between old smooth and snapshot, so the 13-bit truncation is exact.
  assign diff       = $signed({1'b0, cur_snap}) - $signed({1'b0, cur_smooth});
  assign step       = diff >>> ALPHA_SHIFT;
  assign sum        = $signed({1'b0, cur_smooth}) + step;
  assign smooth_new = sum[MAG_W-1:0];

  assign decayed   = (cur_hold > DECAY) ? (cur_hold - DECAY) : '0;
  assign hold_new  = (smooth_new > decayed) ? smooth_new : decayed;
  assign in_search = (idx_q >= LO_BIN) && (idx_q <= HI_BIN);

  msb_level u_msb_level (
    .value (hold_new),
    .level (level_new)
  );

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    state_d      = state_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    smooth_d     = smooth_q;
    hold_d       = hold_q;
    level_d      = level_q;
    best_bin_d   = best_bin_q;
    best_mag_d   = best_mag_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          snap_d     = mag;
          idx_d      = '0;
          best_bin_d = LO_BIN;
          best_mag_d = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        smooth_d[idx_q] = smooth_new;
        hold_d[idx_q]   = hold_new;
        level_d[idx_q]  = level_new;
        // Strict compare keeps the lowest index on ties.
        if (in_search && (smooth_new > best_mag_q)) begin
          best_bin_d = idx_q;
          best_mag_d = smooth_new;
        end
        if (idx_q == LAST_BIN) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        peak_bin_d   = best_bin_q;
        peak_mag_d   = best_mag_q;
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the per-bin arrays are small register files feeding outputs, so they are reset like any other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      state_q      <= IDLE;
      idx_q        <= '0;
      snap_q       <= '{default: '0};
      smooth_q     <= '{default: '0};
      hold_q       <= '{default: '0};
      level_q      <= '{default: '0};
      best_bin_q   <= '0;
      best_mag_q   <= '0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge value of every other.
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      smooth_q     <= smooth_d;
      hold_q       <= hold_d;
      level_q      <= level_d;
      best_bin_q   <= best_bin_d;
      best_mag_q   <= best_mag_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign smooth     = smooth_q;
  assign hold       = hold_q;
  assign level      = level_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_spectrum_peak_tracker.sv
// Self-checking bench: two trackers (smoothing shifts 2 and 0) against a frame-level reference model.
module tb_spectrum_peak_tracker;
  import spectrum_pkg::*;

  localparam int P     = 40;
  localparam int DECAY = 64;
  localparam int LO    = 1;
  localparam int HI    = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [MAG_W-1:0]   mag [NBINS];
  logic [MAG_W-1:0]   smooth_a [NBINS], smooth_b [NBINS];
  logic [MAG_W-1:0]   hold_a [NBINS], hold_b [NBINS];
  logic [LEVEL_W-1:0] level_a [NBINS], level_b [NBINS];
  logic [2:0]         peak_bin_a, peak_bin_b;
  logic [MAG_W-1:0]   peak_mag_a, peak_mag_b;
  logic               frame_done_a, frame_done_b;

  always #5 clk = ~clk;

  spectrum_peak_tracker #(
    .FCLK(P), .UPDATE_HZ(1), .ALPHA_SHIFT(2), .DECAY_STEP(DECAY), .SEARCH_LO(LO), .SEARCH_HI(HI)
  ) dut_a (
    .clk(clk), .reset(reset), .mag(mag), .smooth(smooth_a), .hold(hold_a), .level(level_a),
    .peak_bin(peak_bin_a), .peak_mag(peak_mag_a), .frame_done(frame_done_a)
  );

  spectrum_peak_tracker #(
    .FCLK(P), .UPDATE_HZ(1), .ALPHA_SHIFT(0), .DECAY_STEP(DECAY), .SEARCH_LO(LO), .SEARCH_HI(HI)
  ) dut_b (
    .clk(clk), .reset(reset), .mag(mag), .smooth(smooth_b), .hold(hold_b), .level(level_b),
    .peak_bin(peak_bin_b), .peak_mag(peak_mag_b), .frame_done(frame_done_b)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int e0    = -100;
  bit exp_fd = 1'b0;
  int ks [2] = '{2, 0};

  // Visible model outputs, and the values computed for the frame in flight.
  int m_sm [2][NBINS], m_hd [2][NBINS], m_lv [2][NBINS], m_pb [2], m_pm [2];
  int f_sm [2][NBINS], f_hd [2][NBINS], f_lv [2][NBINS], f_pb [2], f_pm [2];

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int floor_div_pow2(input int v, input int k);
    int q = 1 << k;
    if (v >= 0) return v / q;
    return -((-v + q - 1) / q);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NBINS; i++) begin
        m_sm[d][i] = 0; m_hd[d][i] = 0; m_lv[d][i] = 0;
      end
      m_pb[d] = 0; m_pm[d] = 0;
    end
  endtask

  // Whole-frame result from the current inputs and the previously committed state.
  task automatic compute_frame();
    for (int d = 0; d < 2; d++) begin
      f_pb[d] = LO;
      f_pm[d] = 0;
      for (int i = 0; i < NBINS; i++) begin
        int snap = int'(mag[i]);
        int dec  = (m_hd[d][i] > DECAY) ? m_hd[d][i] - DECAY : 0;
        f_sm[d][i] = m_sm[d][i] + floor_div_pow2(snap - m_sm[d][i], ks[d]);
        f_hd[d][i] = (f_sm[d][i] > dec) ? f_sm[d][i] : dec;
        f_lv[d][i] = $clog2(f_hd[d][i] + 1);
        if (i >= LO && i <= HI && f_sm[d][i] > f_pm[d]) begin
          f_pb[d] = i;
          f_pm[d] = f_sm[d][i];
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NBINS; i++) begin
      check($sformatf("a.smooth[%0d]", i), int'(smooth_a[i]), m_sm[0][i]);
      check($sformatf("a.hold[%0d]", i),   int'(hold_a[i]),   m_hd[0][i]);
      check($sformatf("a.level[%0d]", i),  int'(level_a[i]),  m_lv[0][i]);
      check($sformatf("b.smooth[%0d]", i), int'(smooth_b[i]), m_sm[1][i]);
      check($sformatf("b.hold[%0d]", i),   int'(hold_b[i]),   m_hd[1][i]);
      check($sformatf("b.level[%0d]", i),  int'(level_b[i]),  m_lv[1][i]);
    end
    check("a.peak_bin", int'(peak_bin_a), m_pb[0]);
    check("a.peak_mag", int'(peak_mag_a), m_pm[0]);
    check("b.peak_bin", int'(peak_bin_b), m_pb[1]);
    check("b.peak_mag", int'(peak_mag_b), m_pm[1]);
    check("a.frame_done", int'(frame_done_a), int'(exp_fd));
    check("b.frame_done", int'(frame_done_b), int'(exp_fd));
  endtask

  // One clock: snapshot on tick edges, commit bin i at E0+1+i and the peak at E0+9.
  task automatic tick_cycle();
    @(posedge clk);
    cyc++;
    if (cyc % P == 0) begin
      compute_frame();
      e0 = cyc;
    end
    exp_fd = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NBINS; i++) begin
        if (cyc == e0 + 1 + i) begin
          m_sm[d][i] = f_sm[d][i]; m_hd[d][i] = f_hd[d][i]; m_lv[d][i] = f_lv[d][i];
        end
      end
      if (cyc == e0 + 9) begin
        m_pb[d] = f_pb[d]; m_pm[d] = f_pm[d];
      end
    end
    if (cyc == e0 + 9) exp_fd = 1'b1;
    @(negedge clk);
    compare_all();
    if (frame_done_a) check("latency", cyc - e0, 9);
  endtask

  task automatic run_to_commit();
    for (int n = 0; n < 2 * P; n++) begin
      tick_cycle();
      if (cyc >= P + 9 && (cyc - 9) % P == 0) return;
    end
    check("commit_timeout", 0, 1);
  endtask

  task automatic run_to_offset(input int off);
    for (int n = 0; n < 2 * P; n++) begin
      tick_cycle();
      if (cyc >= P && cyc % P == off) return;
    end
    check("offset_timeout", 0, 1);
  endtask

  task automatic do_reset(input bool_unused_dummy = 0, input int hold_cycles = 3);
    reset = 1'b1;
    @(negedge clk);
    #1;
    model_clear();
    cyc    = 0;
    e0     = -100;
    exp_fd = 1'b0;
    compare_all();
    for (int n = 0; n < hold_cycles; n++) begin
      @(negedge clk);
      compare_all();
    end
    reset = 1'b0;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < NBINS; i++) mag[i] = MAG_W'(v);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int s1_exp [3] = '{250, 437, 577};

    set_all(0);
    model_clear();
    do_reset(0, 3);

    // Constant tone on bin 3 with shift 2.
    mag[3] = 13'd1000;
    for (int f = 0; f < 3; f++) begin
      run_to_commit();
      check("s1.smooth3", int'(smooth_a[3]), s1_exp[f]);
      check("s1.peak_bin", int'(peak_bin_a), 3);
      if (f == 0) check("s1.level3", int'(level_a[3]), 8);
    end

    // Tie between bins 2 and 4, large DC excluded from the search.
    set_all(0);
    mag[0] = 13'd8000; mag[2] = 13'd500; mag[4] = 13'd500;
    run_to_commit();
    check("tie.peak_bin", int'(peak_bin_b), 2);
    check("tie.peak_mag", int'(peak_mag_b), 500);

    // Peak-hold decay on bin 5 down to zero, without wrapping.
    set_all(0);
    mag[5] = 13'd1000;
    run_to_commit();
    check("decay.hold5_start", int'(hold_b[5]), 1000);
    mag[5] = '0;
    for (int j = 1; j <= 17; j++) begin
      run_to_commit();
      check($sformatf("decay.hold5_f%0d", j), int'(hold_b[5]), (1000 - 64 * j > 0) ? 1000 - 64 * j : 0);
    end

    // Input change after the snapshot edge lands in the next frame only.
    mag[1] = 13'd100;
    run_to_offset(3);
    mag[1] = 13'd4000;
    run_to_commit();
    check("snap.cur_frame", int'(smooth_b[1]), 100);
    run_to_commit();
    check("snap.next_frame", int'(smooth_b[1]), 4000);

    // Reset in the middle of a scan.
    run_to_offset(4);
    do_reset(0, 3);
    check("rst.smooth1", int'(smooth_b[1]), 0);
    check("rst.frame_done", int'(frame_done_a), 0);
    run_to_commit();
    check("rst.first_commit_cycle", cyc, P + 9);

    // Randomised frames, some quantised coarsely to provoke ties.
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < NBINS; i++) begin
        if (f % 3 == 0) mag[i] = MAG_W'($urandom_range(0, 3) * 100);
        else            mag[i] = MAG_W'($urandom_range(0, 8191));
      end
      if (f % 5 == 4) run_to_offset($urandom_range(1, 8));
      if (f % 5 == 4) mag[$urandom_range(0, 7)] = MAG_W'($urandom_range(0, 8191));
      run_to_commit();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spectrum_peak_tracker.md
# spectrum_peak_tracker

Consumes the eight 13-bit FFT bin magnitudes produced by the FFT interface stage. On a fixed update tick it snapshots all bins and applies per-bin exponential smoothing and per-bin peak-hold with linear decay. It then finds the dominant bin and produces 4-bit bar levels for the display stage. It sits directly between the FFT magnitude output and the LED/7-segment drivers.

## Interface
- `FCLK`, 50_000_000: clock frequency in Hz.
- `UPDATE_HZ`, 30: frame (update) rate in Hz. Constraint: FCLK/UPDATE_HZ ≥ 16; violating it is an elaboration error.
- `ALPHA_SHIFT`, 2: smoothing shift k, range 0..6; k = 0 disables smoothing.
- `DECAY_STEP`, 64: peak-hold decrement per frame.
- `SEARCH_LO`, 1: lowest bin included in the peak search. The default excludes DC.
- `SEARCH_HI`, 4: highest bin included in the peak search; bins 5..7 mirror bins 3..1.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mag[0:7]` in 8×13: unsigned bin magnitudes. Free-running, with no strobe.
- `smooth[0:7]` out 8×13: smoothed magnitudes.
- `hold[0:7]` out 8×13: peak-hold magnitudes.
- `level[0:7]` out 8×4: bar height, 0..13.
- `peak_bin` out 3: index of the largest `smooth` value in SEARCH_LO..SEARCH_HI.
- `peak_mag` out 13: `smooth[peak_bin]`.
- `frame_done` out 1: one-cycle pulse when a frame's outputs are committed.

## Operation
- **Reset:** all outputs, snapshot registers, the tick counter and the FSM go to 0 / IDLE.
- **Tick counter:** counts 0..PERIOD-1, with PERIOD = FCLK/UPDATE_HZ. On reaching PERIOD-1 it wraps to 0 and raises `tick`. It runs regardless of FSM state.
- **IDLE:** on `tick`, latch all eight `mag` into `snap[0:7]`, clear `idx`, `best_bin` and `best_mag`, then go to SCAN.
- **SCAN:** handles one bin per cycle, with i = `idx`.
  - Smoothing: d = {0,snap[i]} − {0,smooth[i]} as a 14-bit signed value. smooth'[i] = smooth[i] + (d >>> ALPHA_SHIFT), truncated to 13 bits. The result always lies between the old `smooth[i]` and `snap[i]` inclusive, so it never overflows.
  - Known behaviour: the floor shift lets `smooth` settle up to 2^k−1 below a constant input. This is accepted.
  - Peak hold: hold'[i] = max(smooth'[i], sat0(hold[i] − DECAY_STEP)).
  - Level: level'[i] = 0 if hold'[i] = 0, otherwise floor(log2(hold'[i])) + 1.
  - Peak search: if SEARCH_LO ≤ i ≤ SEARCH_HI and smooth'[i] > best_mag (strict), then best ← (i, smooth'[i]). Equal values therefore resolve to the lowest index.
  - After idx = 7, go to DONE.
- **DONE:** set `peak_bin` ← best_bin, `peak_mag` ← best_mag, pulse `frame_done`, return to IDLE.
- If no searched bin exceeds 0, the result is `peak_bin` = SEARCH_LO and `peak_mag` = 0.
- A `tick` arriving outside IDLE cannot occur given the PERIOD constraint. It is nonetheless ignored and does not restart the scan.
- Changes on `mag` after the snapshot edge have no effect on the current frame.
- Asserting `reset` mid-SCAN aborts the frame: all state clears immediately and no `frame_done` is produced.

## Timing
- Edge E0 is the `tick` edge, where the snapshot is latched.
- `smooth[i]`, `hold[i]` and `level[i]` update at edge E0+1+i.
- `peak_bin`, `peak_mag` and `frame_done` update at edge E0+9. `frame_done` is high for exactly the cycle following E0+9.
- Total latency from `tick` to committed frame is 9 clocks. All outputs are registered.
- Outputs stay stable between updates. `peak_*` is stable for at least PERIOD−9 cycles after `frame_done`.

## Structure
- Package `spectrum_pkg` holds:
  - `NBINS` = 8, `MAG_W` = 13, `LEVEL_W` = 4;
  - the typedef `mag_t` = logic [12:0];
  - the enum `tracker_state_t` {IDLE, SCAN, DONE}.
- Sub-module `msb_level`: a combinational 13-bit to 4-bit leading-one encoder used for `level`. It is instantiated once, on the SCAN datapath.

## Test plan
- **Reset:** assert `reset` mid-simulation → all outputs read 0, `frame_done` stays low, and the next frame starts only at the next natural tick.
- **Smoothing and peak:** `mag[3]` = 1000 constant, all others 0, ALPHA_SHIFT = 2 → `smooth[3]` = 250, 437, 577 after frames 1–3; `peak_bin` = 3; `level[3]` = 8 after frame 1.
- **Tie and DC exclusion:** `mag[0]` = 8000, `mag[2]` = `mag[4]` = 500, ALPHA_SHIFT = 0 → `peak_bin` = 2, `peak_mag` = 500.
- **Decay:** with `hold[5]` = 1000, drop all `mag` to 0 and use ALPHA_SHIFT = 0 → `hold[5]` = 936, 872, … down to 0 after 16 frames (saturating, never wrapping).
- **Snapshot isolation:** change `mag[1]` from 100 to 4000 on edge E0+3 → the current frame uses 100, and the next frame uses 4000.
- **Latency:** measure from `tick` to `frame_done` → exactly 9 clocks; `frame_done` high for 1 cycle per PERIOD.
